sram_port_arb: RTL and testbench
================================

# sram_port_arb

Parametrised multi-channel arbiter for one external 16-bit asynchronous SRAM chip. It sits between the mapper memory-request outputs and one physical `ramN_*` pin group. It replaces the single-owner direct strobe assignment with a registered, wait-state-timed access sequencer. Several requesters (mapper, DMA, save-state, cheats) can share one chip with round-robin fairness, byte-lane writes and guaranteed address/data setup and hold.

## Interface
Parameters:
- `CH`, 4: number of requesting channels, 2..8.
- `AW`, 22: word address width driven to the SRAM.
- `WS`, 3: access wait states (cycles of OE/WE assertion), 1..15.

Ports:
- `clk` in 1: system clock (clk50 domain).
- `rst` in 1: asynchronous, active-low reset.
- `req` in CH: per-channel request level; held until that channel's `ack`.
- `we_lo` in CH: per-channel low-byte write enable. `we_lo` and `we_hi` both 0 means read.
- `we_hi` in CH: per-channel high-byte write enable.
- `addr` in CH*AW: flattened word addresses; channel i is `[i*AW +: AW]`.
- `di` in CH*16: flattened write data; channel i is `[i*16 +: 16]`.
- `ack` out CH: one-cycle completion pulse to the granted channel.
- `rdata` out 16: read data registered from the SRAM; valid while `ack` is high.
- `gnt_idx` out 3: index of the current or last granted channel (debug).
- `ram_addr` out AW: SRAM address.
- `ram_do` out 16: SRAM write data.
- `ram_di` in 16: SRAM read data.
- `ram_dir` out 1: 1 means the block drives SRAM data pins with `ram_do`.
- `ram_ce`, `ram_oe`, `ram_we`, `ram_ub`, `ram_lb` out 1 each: active-low SRAM strobes.

## Operation
- FSM states: IDLE, SETUP, ACCESS, HOLD. All outputs are registered.
- IDLE:
  - If any `req` bit is set, select the winner and latch its addr, di, we_lo and we_hi.
  - Set `gnt_idx`, load the wait counter with WS, and go to SETUP.
- SETUP, 1 cycle:
  - `ram_ce`=0. `ram_addr` holds the latched address.
  - For a write: `ram_dir`=1 and `ram_do` holds the latched data.
  - OE and WE stay high.
- ACCESS, WS cycles; the counter decrements each cycle.
  - Read: `ram_oe`=0, `ram_ub`=0, `ram_lb`=0.
  - Write: `ram_we`=0, `ram_ub`=!we_hi, `ram_lb`=!we_lo.
  - When the counter reaches 1, go to HOLD. On a read, `rdata` latches `ram_di` on that same edge.
- HOLD, 1 cycle:
  - WE and OE are high. `ram_ce`=0. Address and data are held, and `ram_dir` stays at its write value.
  - `ack[gnt]`=1 for this cycle only. Next state is IDLE.
- Leaving HOLD, the block deasserts `ram_ce`, `ram_ub`, `ram_lb` and clears `ram_dir`.
- Arbitration is round-robin with a pointer `ptr`. The search starts at `ptr` and wraps modulo CH. After each grant, `ptr` = gnt+1 mod CH.
- A `req` dropped before it is granted is simply not served.
- Once a request is granted, the transaction completes even if its `req` falls. `ack` is still issued.
- Input changes after the IDLE latch edge have no effect on the current access.
- Only one channel's `ack` can be high in any cycle. Non-granted channels see `ack`=0.

## Timing
- Reset values: all strobes 1, `ram_dir`=0, `ack`=0, `rdata`=0, `ram_addr`=0, `ram_do`=0, `gnt_idx`=0, `ptr`=0, state IDLE.
- Reset asserted mid-access: all strobes go high and `ram_dir` goes to 0 asynchronously. No `ack` is produced, and the aborted request is not replayed.
- Latency:
  - `req` is sampled high in IDLE at edge 0.
  - SETUP occupies edge 1, ACCESS occupies edges 2..WS+1, and `ack` is high in cycle WS+2.
  - With WS=3, `ack` arrives in the 5th cycle after sampling.
- Throughput: at most one access per WS+3 cycles, because IDLE always lasts at least one cycle.
- Write timing:
  - Address and data are stable for 1 cycle before WE falls.
  - Address and data are held for 1 cycle after WE rises.
  - WE is low for exactly WS cycles.
- Counter width is 4 bits. WS=0 or CH>8 is rejected by elaboration-time checks.

## Configuration
- `SRAM_ARB_FIXPRI_EN` defined:
  - Channel 0 wins any IDLE arbitration in which `req[0]`=1, regardless of `ptr`.
  - Channels 1..CH-1 share the remaining slots round-robin, and `ptr` only advances on their grants.
  - Intended for the SMD bus channel, which has hard real-time latency.
- `SRAM_ARB_FIXPRI_EN` undefined: pure round-robin across all channels as described above.

## Test plan
- Single read: ch1 reads addr 0x12345 with WS=3, `ram_di`=0xBEEF. Required: `ram_oe` is low for exactly 3 cycles, `ack[1]` pulses in the 5th cycle, and `rdata`=0xBEEF.
- Low-byte write: ch2 writes di=0xA55A with `we_lo`=1. Required: `ram_lb`=0 and `ram_ub`=1 during ACCESS, and `ram_do`=0xA55A from SETUP through HOLD.
- Contention: `req`=4'b1111 held continuously with WS=3. Required: acks arrive in order ch0, ch1, ch2, ch3, spaced 6 cycles apart, and then repeat from ch0.
- Fairness: after ch2 is served, assert `req`=4'b0101. Required: ch0 is granted next (the search starts at ptr=3 and wraps), then ch2.
- Reset abort: assert `rst` low during the 2nd ACCESS cycle of a write. Required: `ram_we`, `ram_ce` and `ram_dir` return to idle immediately, no `ack` is produced, and the next grant after release starts from ch0.
- With `SRAM_ARB_FIXPRI_EN` defined, `req[0]` and `req[3]` held continuously. Required: ch0 wins every arbitration and ch3 is never acked until `req[0]` falls; without the macro, they alternate.

Source files
------------

// File: rtl/sram_port_arb.sv
// sram_port_arb: round-robin wait-state sequencer sharing one async 16-bit SRAM; SRAM_ARB_FIXPRI_EN gives channel 0 fixed priority
module sram_port_arb #(
  parameter int CH = 4,
  parameter int AW = 22,
  parameter int WS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH-1:0]    req,
  input  logic [CH-1:0]    we_lo,
  input  logic [CH-1:0]    we_hi,
  input  logic [CH*AW-1:0] addr,
  input  logic [CH*16-1:0] di,
  output logic [CH-1:0]    ack,
  output logic [15:0]      rdata,
  output logic [2:0]       gnt_idx,
  output logic [AW-1:0]    ram_addr,
  output logic [15:0]      ram_do,
  input  logic [15:0]      ram_di,
  output logic             ram_dir,
  output logic             ram_ce,
  output logic             ram_oe,
  output logic             ram_we,
  output logic             ram_ub,
  output logic             ram_lb
);
  localparam int IW = $clog2(CH);
  localparam int JW = IW + 1;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;
  state_t state;
  logic [3:0] cnt;
  logic [IW-1:0] ptr, win, nxt;
  logic [JW-1:0] idx;
  logic wl, wh, wr;
  if (CH < 2 || CH > 8 || WS < 1 || WS > 15) begin : g_bad_param
    $error("sram_port_arb: CH must be 2..8 and WS 1..15");
  end
  assign wr = wl | wh;
  assign nxt = (win == IW'(CH - 1)) ? '0 : win + IW'(1);
  // lowest offset from ptr wins, so scan offsets downward and let later hits override
  always_comb begin
    win = '0;
    idx = '0;
    for (int k = CH - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + JW'(k);
      idx = (idx >= JW'(CH)) ? idx - JW'(CH) : idx;
      win = req[idx[IW-1:0]] ? idx[IW-1:0] : win;
    end
`ifdef SRAM_ARB_FIXPRI_EN
    win = req[0] ? '0 : win;
`endif
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ptr      <= '0;
      wl       <= 1'b0;
      wh       <= 1'b0;
      ack      <= '0;
      rdata    <= '0;
      gnt_idx  <= '0;
      ram_addr <= '0;
      ram_do   <= '0;
      ram_dir  <= 1'b0;
      ram_ce   <= 1'b1;
      ram_oe   <= 1'b1;
      ram_we   <= 1'b1;
      ram_ub   <= 1'b1;
      ram_lb   <= 1'b1;
    end else begin
      case (state)
        IDLE: if (|req) begin
          state    <= SETUP;
          gnt_idx  <= 3'(win);
          cnt      <= 4'(WS);
          ram_addr <= addr[int'(win)*AW +: AW];
          ram_do   <= di[int'(win)*16 +: 16];
          wl       <= we_lo[win];
          wh       <= we_hi[win];
          ram_dir  <= we_lo[win] | we_hi[win];
          ram_ce   <= 1'b0;
`ifdef SRAM_ARB_FIXPRI_EN
          if (win != '0) ptr <= nxt;
`else
          ptr <= nxt;
`endif
        end
        SETUP: begin
          state  <= ACCESS;
          ram_oe <= wr;
          ram_we <= !wr;
          ram_ub <= wr & !wh;
          ram_lb <= wr & !wl;
        end
        ACCESS: if (cnt == 4'd1) begin
          state  <= HOLD;
          ram_oe <= 1'b1;
          ram_we <= 1'b1;
          ack    <= CH'(1) << gnt_idx;
          if (!wr) rdata <= ram_di;
        end else begin
          cnt <= cnt - 4'd1;
        end
        HOLD: begin
          state   <= IDLE;
          ack     <= '0;
          ram_ce  <= 1'b1;
          ram_ub  <= 1'b1;
          ram_lb  <= 1'b1;
          ram_dir <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_port_arb.sv
// tb_sram_port_arb: randomized transaction-level check of sram_port_arb against a grant/memory reference model
module tb_sram_port_arb;
  localparam int CH = 4;
  localparam int AW = 22;
  localparam int WS = 3;
  logic clk = 1'b0;
  logic rst;
  logic [CH-1:0] req, we_lo, we_hi, ack;
  logic [CH*AW-1:0] addr;
  logic [CH*16-1:0] di;
  logic [15:0] rdata, ram_do, ram_di;
  logic [2:0] gnt_idx;
  logic [AW-1:0] ram_addr;
  logic ram_dir, ram_ce, ram_oe, ram_we, ram_ub, ram_lb;
  logic [15:0] sram [64];
  logic [15:0] ref_mem [64];
  bit pend [CH];
  bit p_wl [CH];
  bit p_wh [CH];
  logic [AW-1:0] p_addr [CH];
  logic [15:0] p_di [CH];
  int ptr_m, last, n_chk, n_fail;

  always #5 clk = ~clk;

  sram_port_arb #(.CH(CH), .AW(AW), .WS(WS)) dut (
    .clk(clk), .rst(rst), .req(req), .we_lo(we_lo), .we_hi(we_hi),
    .addr(addr), .di(di), .ack(ack), .rdata(rdata), .gnt_idx(gnt_idx),
    .ram_addr(ram_addr), .ram_do(ram_do), .ram_di(ram_di), .ram_dir(ram_dir),
    .ram_ce(ram_ce), .ram_oe(ram_oe), .ram_we(ram_we), .ram_ub(ram_ub), .ram_lb(ram_lb)
  );

  // behavioural SRAM chip on the pins
  assign ram_di = (!ram_oe && !ram_ce) ? sram[ram_addr[5:0]] : 16'hdead;
  always @(negedge clk) begin
    if (!ram_ce && !ram_we) begin
      if (!ram_lb) sram[ram_addr[5:0]][7:0] <= ram_do[7:0];
      if (!ram_ub) sram[ram_addr[5:0]][15:8] <= ram_do[15:8];
    end
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < CH; i++) begin
      req[i] = pend[i];
      we_lo[i] = p_wl[i];
      we_hi[i] = p_wh[i];
      addr[i*AW +: AW] = p_addr[i];
      di[i*16 +: 16] = p_di[i];
    end
  endtask

  task automatic set_req(int c, bit wl, bit wh, logic [AW-1:0] a, logic [15:0] d);
    pend[c] = 1'b1;
    p_wl[c] = wl;
    p_wh[c] = wh;
    p_addr[c] = a;
    p_di[c] = d;
  endtask

  task automatic rand_req(int c);
    logic [AW-1:0] a;
    a = AW'($urandom);
    a[5:4] = 2'b00;
    set_req(c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 16'($urandom));
  endtask

  function automatic int pick();
`ifdef SRAM_ARB_FIXPRI_EN
    if (pend[0]) return 0;
`endif
    for (int k = 0; k < CH; k++)
      if (pend[(ptr_m + k) % CH]) return (ptr_m + k) % CH;
    return 0;
  endfunction

  // waits for one ack, checking grant choice, latency, strobe counts and pin stability
  task automatic serve(int lat);
    int e, ce_n, oe_n, we_n, bad, got;
    bit wr, done;
    e = pick();
    wr = p_wl[e] | p_wh[e];
    ce_n = 0; oe_n = 0; we_n = 0; bad = 0; done = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge clk);
      if (!ram_ce) begin
        ce_n++;
        if (ram_addr !== p_addr[e] || ram_dir !== wr || (wr && ram_do !== p_di[e])) bad++;
      end else if (!ram_ub || !ram_lb || ram_dir) bad++;
      if (!ram_oe) oe_n++;
      if (!ram_we) we_n++;
      if ((!ram_oe || !ram_we) &&
          (ram_ub !== (wr & !p_wh[e]) || ram_lb !== (wr & !p_wl[e]) || (!ram_oe && !ram_we))) bad++;
      if (ack != '0) begin
        done = 1'b1;
        got = -1;
        for (int i = 0; i < CH; i++) if (ack[i]) got = i;
        check("lat", c, lat);
        check("ack_onehot", $countones(ack), 1);
        check("ack_ch", got, e);
        check("gnt_idx", {29'd0, gnt_idx}, e);
        check("ce_cycles", ce_n, WS + 2);
        check("oe_cycles", oe_n, wr ? 0 : WS);
        check("we_cycles", we_n, wr ? WS : 0);
        check("pins", bad, 0);
        if (!wr) check("rdata", {16'd0, rdata}, {16'd0, ref_mem[p_addr[e][5:0]]});
        if (p_wl[e]) ref_mem[p_addr[e][5:0]][7:0] = p_di[e][7:0];
        if (p_wh[e]) ref_mem[p_addr[e][5:0]][15:8] = p_di[e][15:8];
`ifdef SRAM_ARB_FIXPRI_EN
        if (e != 0) ptr_m = (e + 1) % CH;
`else
        ptr_m = (e + 1) % CH;
`endif
        pend[e] = 1'b0;
        last = e;
        drive();
      end
    end
    if (!done) check("ack_timeout", 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_fail = 0; ptr_m = 0; last = 0;
    rst = 1'b0;
    req = '0; we_lo = '0; we_hi = '0; addr = '0; di = '0;
    for (int i = 0; i < 64; i++) begin
      sram[i] = 16'($urandom);
      ref_mem[i] = sram[i];
    end
    for (int i = 0; i < CH; i++) begin
      pend[i] = 1'b0; p_wl[i] = 1'b0; p_wh[i] = 1'b0; p_addr[i] = '0; p_di[i] = '0;
    end
    repeat (3) @(negedge clk);
    check("rst_strobes", {27'd0, ram_ce, ram_oe, ram_we, ram_ub, ram_lb}, 32'h1f);
    check("rst_dir", {31'd0, ram_dir}, 0);
    check("rst_ack", {28'd0, ack}, 0);
    check("rst_rdata", {16'd0, rdata}, 0);
    check("rst_addr", {10'd0, ram_addr}, 0);
    check("rst_do", {16'd0, ram_do}, 0);
    check("rst_gnt", {29'd0, gnt_idx}, 0);
    rst = 1'b1;
    @(negedge clk);
    sram[6'h05] = 16'hbeef;
    ref_mem[6'h05] = 16'hbeef;
    set_req(1, 1'b0, 1'b0, 22'h12345, 16'h0000);
    drive();
    serve(WS + 2);
    set_req(2, 1'b1, 1'b0, 22'h00abc, 16'ha55a);
    drive();
    serve(WS + 3);
    rand_req(0);
    rand_req(2);
    drive();
    serve(WS + 3);
    serve(WS + 3);
    repeat (2) @(negedge clk);
    // abort a write in its second ACCESS cycle
    set_req(2, 1'b1, 1'b1, 22'h003f30, 16'h1234);
    drive();
    repeat (3) @(negedge clk);
    check("abort_we_was_low", {31'd0, ram_we}, 0);
    rst = 1'b0;
    #1;
    check("abort_we", {31'd0, ram_we}, 1);
    check("abort_ce", {31'd0, ram_ce}, 1);
    check("abort_dir", {31'd0, ram_dir}, 0);
    ref_mem[6'h30] = 16'h1234;
    pend[2] = 1'b0;
    drive();
    ptr_m = 0;
    repeat (2) begin
      @(negedge clk);
      check("abort_no_ack", {28'd0, ack}, 0);
    end
    rst = 1'b1;
    rand_req(0);
    rand_req(3);
    drive();
    serve(WS + 2);
    serve(WS + 3);
    for (int i = 0; i < CH; i++) rand_req(i);
    drive();
    for (int n = 0; n < 8; n++) begin
      serve(WS + 3);
      rand_req(last);
      drive();
    end
    for (int i = 0; i < CH; i++) pend[i] = 1'b0;
    rand_req(0);
    rand_req(3);
    drive();
    for (int n = 0; n < 6; n++) begin
      serve(WS + 3);
      rand_req(last);
      drive();
    end
    pend[0] = 1'b0;
    drive();
    serve(WS + 3);
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < CH; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1) rand_req(i);
      if (!(pend[0] || pend[1] || pend[2] || pend[3])) rand_req(int'($urandom_range(0, CH - 1)));
      drive();
      serve(WS + 3);
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
